// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, held in EX via stall.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |divisor| > |dividend|.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_valid,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            kill,
    output logic            stall,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement negate when the flag is set; wraps for the most negative value.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        logic signed [XLEN-1:0] s;
        s = v;
        return n ? -s : s;
    endfunction

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic            q_neg, r_neg, is_rem;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    // Operand decode for capture in IDLE
    logic            is_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf, early, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_signed = ~div_op[0];
        a_neg     = is_signed & rs1_data[XLEN-1];
        b_neg     = is_signed & rs2_data[XLEN-1];
        a_mag     = neg_if(rs1_data, a_neg);
        b_mag     = neg_if(rs2_data, b_neg);
        div_zero  = (rs2_data == '0);
        ovf       = is_signed && (rs1_data == INT_MIN) && (rs2_data == '1);
`ifdef DIV_EARLY_OUT_EN
        early     = !div_zero && (b_mag > a_mag);
`else
        early     = 1'b0;
`endif
        special   = div_zero | ovf | early;
        if (div_zero)
            special_res = div_op[1] ? rs1_data : '1;
        else if (ovf)
            special_res = div_op[1] ? '0 : INT_MIN;
        else
            special_res = div_op[1] ? rs1_data : '0;
    end

    // One restoring step: trial-subtract the divisor from the shifted partial remainder
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_nxt, quo_nxt, fin;

    always_comb begin
        diff    = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
        rem_nxt = diff[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : diff[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
        fin     = is_rem ? neg_if(rem_nxt, r_neg) : neg_if(quo_nxt, q_neg);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            is_rem   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (kill) begin
            state    <= IDLE;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q   <= 1'b0;
                    result_q <= '0;
                    if (div_valid) begin
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        is_rem <= div_op[1];
                        if (special) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state  <= BUSY;
                            cnt    <= '0;
                            rem_q  <= '0;
                            quo_q  <= a_mag;
                            dvsr_q <= b_mag;
                        end
                    end
                end
                BUSY: begin
                    if (!div_valid) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN-1)) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= fin;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    done_q   <= 1'b0;
                    result_q <= '0;
                end
                default: begin
                    state    <= IDLE;
                    done_q   <= 1'b0;
                    result_q <= '0;
                end
            endcase
        end
    end

    assign stall      = div_valid && (state != DONE) && !kill;
    assign div_done   = done_q;
    assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: results queued at issue, compared when div_done rises.
module tb_div_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            div_valid;
    logic [1:0]      div_op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            kill;
    logic            stall;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_valid  (div_valid),
        .div_op     (div_op),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .kill       (kill),
        .stall      (stall),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Reference result using native truncating division plus the RISC-V special cases
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb, r;
        sa = a;
        sb = b;
        case (op)
            2'b00: if (b == 0) r = '1;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                   else r = sa / sb;
            2'b01: r = (b == 0) ? '1 : a / b;
            2'b10: if (b == 0) r = sa;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                   else r = sa % sb;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_stall(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        logic sgn;
        sgn = ~op[0];
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        begin : early_chk
            logic [31:0] am, bm;
            am = (sgn && a[31]) ? -a : a;
            bm = (sgn && b[31]) ? -b : b;
            if (bm > am) return 1;
        end
`endif
        return XLEN + 1;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int stall_cnt;
        int cyc;
        logic [31:0] e;
        @(negedge clk);
        div_valid = 1'b1;
        div_op    = op;
        rs1_data  = a;
        rs2_data  = b;
        exp_q.push_back(exp);
        stall_cnt = 0;
        cyc       = 0;
        while (!div_done && cyc < 200) begin
            #1;
            if (stall) stall_cnt++;
            @(negedge clk);
            cyc++;
        end
        if (!div_done) begin
            check({tag, " timeout"}, {31'b0, div_done}, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            #1;
            check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(ref_stall(op, a, b)));
            check({tag, " stall_in_done"}, {31'b0, stall}, 32'd0);
            e = exp_q.pop_front();
            check({tag, " result"}, div_result, e);
        end
        div_valid = 1'b0;
        @(negedge clk);
        check({tag, " done_drop"}, {31'b0, div_done}, 32'd0);
        check({tag, " result_zero"}, div_result, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        rst_n     = 1'b0;
        div_valid = 1'b0;
        kill      = 1'b0;
        div_op    = 2'b00;
        rs1_data  = '0;
        rs2_data  = '0;
        repeat (2) @(negedge clk);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset done", {31'b0, div_done}, 32'd0);
        check("reset result", div_result, 32'd0);
        rst_n = 1'b1;

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
        do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
        do_op("divu_5_0",   2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
        do_op("rem_5_0",    2'b10, 32'd5, 32'd0, 32'd5);
        do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("divu_3_10",  2'b01, 32'd3, 32'd10, 32'd0);
        do_op("remu_3_10",  2'b11, 32'd3, 32'd10, 32'd3);
        do_op("rem_m3_10",  2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD);
        do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        // Kill at iteration 10 of DIVU 100/7
        @(negedge clk);
        div_valid = 1'b1;
        div_op    = 2'b01;
        rs1_data  = 32'd100;
        rs2_data  = 32'd7;
        repeat (11) @(negedge clk);
        kill = 1'b1;
        #1;
        check("kill stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        kill      = 1'b0;
        div_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("kill no_done", {31'b0, div_done}, 32'd0);
            @(negedge clk);
        end
        do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3);

        // Reset pulse at iteration 5
        @(negedge clk);
        div_valid = 1'b1;
        div_op    = 2'b01;
        rs1_data  = 32'd100;
        rs2_data  = 32'd7;
        repeat (6) @(negedge clk);
        rst_n     = 1'b0;
        div_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst stall", {31'b0, stall}, 32'd0);
        check("midrst done", {31'b0, div_done}, 32'd0);
        check("midrst result", div_result, 32'd0);
        do_op("div_20_4", 2'b00, 32'd20, 32'd4, 32'd5);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
            if (rb[0] && rop[0] == 1'b0) rb = -rb;
            do_op("rand", rop, ra, rb, ref_result(rop, ra, rb));
        end

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU, located in the EX stage beside the ALU.
- Drives the `stall` input of the pipeline hazard logic. While stall is high, PC, IF/ID and ID/EX are frozen, so the divide instruction stays in EX with its operands stable.
- Result is muxed onto the EX writeback path in the cycle stall drops.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- div_valid  input  1  EX holds a divide-class instruction (opcode 0110011, funct7 0000001, funct3[2]=1)
- div_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_data  input  XLEN  dividend (post-forwarding)
- rs2_data  input  XLEN  divisor (post-forwarding)
- kill  input  1  abort in-flight op (EX flush / jump_branch_taken of an older instruction)
- stall  output  1  to hazard unit; freezes upstream stages
- div_done  output  1  result valid this cycle
- div_result  output  XLEN  quotient or remainder

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, counter=0, internal regs=0, stall=0, div_done=0, div_result=0. Reset mid-operation abandons the op; no output glitch after the edge.
- States:
  - IDLE → BUSY when div_valid && !kill and the inputs are not a special case.
  - IDLE → DONE when div_valid && !kill and the inputs are a special case.
  - BUSY → DONE after counter reaches XLEN-1.
  - DONE → IDLE unconditionally.
- stall = div_valid && (state != DONE) && !kill. Combinational, so it is high in the same cycle the instruction first appears in EX.
- div_done = (state == DONE). div_result is registered and held stable only while div_done=1; it is 0 otherwise.
- Capture in IDLE:
  - Signed ops (DIV/REM) use absolute values of the operands.
  - Record q_neg = rs1[XLEN-1]^rs2[XLEN-1] and r_neg = rs1[XLEN-1]; both are forced to 0 for DIVU/REMU.
- Iteration, one quotient bit per cycle, MSB first, restoring:
  - Shift {rem, quo} left by 1.
  - Compute rem - divisor in XLEN+1 bits; if the result is non-negative, commit it and set the quotient LSB.
- Latency for a normal op: 1 capture + XLEN iterations + 1 DONE = XLEN+2 cycles of div_valid, i.e. stall high for XLEN+1 cycles (33 at XLEN=32).
- Final sign fix on entry to DONE: quotient negated if q_neg, remainder negated if r_neg (two's complement, XLEN bits, wrap allowed).
- Special cases (resolved in IDLE, go straight to DONE, stall high for exactly 1 cycle):
  - Divisor = 0: quotient = all ones, remainder = rs1 (unmodified). Applies to signed and unsigned ops.
  - Signed overflow (rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF, DIV/REM only): quotient = 0x8000_0000, remainder = 0.
- kill handling:
  - kill in any state forces state=IDLE next cycle; stall is 0 during the kill cycle and div_done is not raised.
  - kill has priority over a coincident div_valid.
- Back-to-back divides: the DONE cycle releases the pipeline; the next divide reaches EX when state is already IDLE and starts with no bubble.
- div_valid dropping while BUSY (not expected without kill) also returns the unit to IDLE; the result is discarded.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |divisor| > |dividend| (magnitudes after sign handling, divisor non-zero), skip BUSY and go to DONE with quotient 0 and remainder = rs1 (original signed value); stall lasts 1 cycle.
- Undefined: these cases take the full XLEN-iteration path and give identical results.

Test Plan:
- DIVU 100/7 (div_valid held while stall=1) → stall high 33 cycles; div_done 1 cycle; result 14. Repeat with REMU → 2.
- DIV -7/2 → 0xFFFF_FFFD (-3); REM -7/2 → 0xFFFF_FFFF (-1); REM 7/-2 → 1.
- Special cases, each with stall high exactly 1 cycle:
  - DIVU 5/0 → 0xFFFF_FFFF.
  - REM 5/0 → 5.
  - DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000.
  - REM 0x8000_0000/0xFFFF_FFFF → 0.
- Assert kill at iteration 10 of DIVU 100/7 → stall 0 that cycle, state IDLE next cycle, no div_done. Then issue DIVU 9/3 → result 3 after normal latency.
- rst_n low for 1 cycle at iteration 5 → all outputs 0 next cycle; a subsequent DIV 20/4 → 5.
- DIV_EARLY_OUT_EN defined: DIVU 3/10 → stall 1 cycle, quotient 0, REMU gives 3. Undefined: same values with 33-cycle stall.
